// File: rtl/cpu_clock_pkg.sv
// Shared types for the CPU clock generator: operating modes and FSM states.
package cpu_clock_pkg;

    typedef enum logic [1:0] {
        CONT    = 2'b00,
        MANUAL  = 2'b01,
        BURST   = 2'b10,
        STOPPED = 2'b11
    } clk_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } clk_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-level debouncer for a raw push button.
// The debounced level follows the synchronised input only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles; press pulses for one
// cycle on each accepted 0->1 change.
module button_debouncer
    import cpu_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Synchronise the button and count consecutive cycles of disagreement.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Register synchroniser, counter and debounced outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/cpu_clock_gen.sv
// CPU clock generator: programmable half-period divider with continuous,
// debounced manual single-step and counted burst modes. Halt is honoured
// only at phase boundaries so a high phase is never cut short.
module cpu_clock_gen
    import cpu_clock_pkg::*;
#(
    parameter int DIV_WIDTH       = 24,
    parameter int STEP_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic                  manual_toggle,
    input  logic                  step_start,
    input  logic [STEP_WIDTH-1:0] step_count,
    input  logic                  halt,
    output logic                  cpu_clk,
    output logic                  cpu_clk_rise,
    output logic                  cpu_clk_fall,
    output logic                  burst_done,
    output logic                  running
);

    clk_mode_e             mode_s;
    logic                  btn_level_s;
    logic                  press_s;
    logic                  cont_ok_s, manual_ok_s, burst_ok_s;
    logic                  phase_end_s;
    logic                  enter_high_s;

    clk_state_e            state_q,        state_d;
    logic [DIV_WIDTH-1:0]  phase_cnt_q,    phase_cnt_d;
    logic [DIV_WIDTH-1:0]  phase_div_q,    phase_div_d;
    logic [STEP_WIDTH-1:0] remaining_q,    remaining_d;
    logic                  burst_active_q, burst_active_d;
    logic                  cpu_clk_q,      cpu_clk_d;
    logic                  rise_q,         rise_d;
    logic                  fall_q,         fall_d;
    logic                  done_q,         done_d;
    logic                  running_q,      running_d;

    assign mode_s = clk_mode_e'(mode);

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .raw    (manual_toggle),
        .level  (btn_level_s),
        .press  (press_s)
    );

    // A press always coincides with the debounced level going high.
    assign cont_ok_s   = (mode_s == CONT) && !halt;
    assign manual_ok_s = (mode_s == MANUAL) && press_s && btn_level_s && !halt;
    assign burst_ok_s  = (mode_s == BURST) && (remaining_q != '0) && !halt;
    assign phase_end_s = (phase_cnt_q == phase_div_q);

    // Next-state, phase counter, burst bookkeeping and output strobes.
    always_comb begin
        state_d        = state_q;
        phase_cnt_d    = phase_cnt_q + DIV_WIDTH'(1);
        phase_div_d    = phase_div_q;
        remaining_d    = remaining_q;
        burst_active_d = burst_active_q;
        done_d         = 1'b0;
        enter_high_s   = 1'b0;

        case (state_q)
            IDLE: begin
                phase_cnt_d = '0;
                if (mode_s != BURST) begin
                    // Leaving burst mode abandons any pending burst silently.
                    remaining_d    = '0;
                    burst_active_d = 1'b0;
                end else if (step_start && (remaining_q == '0)) begin
                    remaining_d    = step_count;
                    burst_active_d = (step_count != '0);
                    done_d         = (step_count == '0);
                end else begin
                    remaining_d = remaining_q;
                end
                if (cont_ok_s || manual_ok_s || burst_ok_s) begin
                    enter_high_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HIGH: begin
                // High phase always runs to completion regardless of halt.
                if (phase_end_s) begin
                    state_d     = LOW;
                    phase_cnt_d = '0;
                    phase_div_d = div;
                end else begin
                    state_d = HIGH;
                end
            end
            LOW: begin
                if (phase_end_s) begin
                    if (mode_s != BURST) begin
                        remaining_d    = '0;
                        burst_active_d = 1'b0;
                    end else begin
                        remaining_d = remaining_q;
                    end
                    if (cont_ok_s || burst_ok_s) begin
                        enter_high_s = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        phase_cnt_d = '0;
                        if ((mode_s == BURST) && burst_active_q && (remaining_q == '0)) begin
                            done_d         = 1'b1;
                            burst_active_d = 1'b0;
                        end else begin
                            done_d = 1'b0;
                        end
                    end
                end else begin
                    state_d = LOW;
                end
            end
            default: begin
                state_d     = IDLE;
                phase_cnt_d = '0;
            end
        endcase

        if (enter_high_s) begin
            state_d     = HIGH;
            phase_cnt_d = '0;
            phase_div_d = div;
            if (mode_s == BURST) begin
                remaining_d = remaining_q - STEP_WIDTH'(1);
            end else begin
                remaining_d = '0;
            end
        end else begin
            enter_high_s = 1'b0;
        end

        cpu_clk_d = (state_d == HIGH);
        rise_d    = (state_d == HIGH) && (state_q != HIGH);
        fall_d    = (state_q == HIGH) && (state_d != HIGH);
        running_d = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            phase_cnt_q    <= '0;
            phase_div_q    <= '0;
            remaining_q    <= '0;
            burst_active_q <= 1'b0;
            cpu_clk_q      <= 1'b0;
            rise_q         <= 1'b0;
            fall_q         <= 1'b0;
            done_q         <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_cnt_q    <= phase_cnt_d;
            phase_div_q    <= phase_div_d;
            remaining_q    <= remaining_d;
            burst_active_q <= burst_active_d;
            cpu_clk_q      <= cpu_clk_d;
            rise_q         <= rise_d;
            fall_q         <= fall_d;
            done_q         <= done_d;
            running_q      <= running_d;
        end
    end

    assign cpu_clk      = cpu_clk_q;
    assign cpu_clk_rise = rise_q;
    assign cpu_clk_fall = fall_q;
    assign burst_done   = done_q;
    assign running      = running_q;

endmodule

// File: tb/tb_cpu_clock_gen.sv
// Scoreboard bench for cpu_clock_gen: scenarios push the cycle numbers at
// which rise/fall/burst_done strobes must appear; a monitor pops and compares.
module tb_cpu_clock_gen;

    localparam int DW = 24;
    localparam int SW = 8;
    localparam int DB = 4;

    logic          sys_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic [1:0]    mode    = 2'b11;
    logic [DW-1:0] div     = '0;
    logic          manual_toggle = 1'b0;
    logic          step_start    = 1'b0;
    logic [SW-1:0] step_count    = '0;
    logic          halt          = 1'b0;
    logic          cpu_clk, cpu_clk_rise, cpu_clk_fall, burst_done, running;

    cpu_clock_gen #(
        .DIV_WIDTH(DW), .STEP_WIDTH(SW), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .mode(mode), .div(div),
        .manual_toggle(manual_toggle), .step_start(step_start),
        .step_count(step_count), .halt(halt), .cpu_clk(cpu_clk),
        .cpu_clk_rise(cpu_clk_rise), .cpu_clk_fall(cpu_clk_fall),
        .burst_done(burst_done), .running(running)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int exp_rise[$];
    int exp_fall[$];
    int exp_done[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: strobe at cycle %0d, expected none", name, cyc);
    endtask

    // Monitor: every strobe must match the next expected cycle number.
    always @(negedge sys_clk) begin
        if (rst_n) begin
            chk("rise_fall_exclusive", int'(cpu_clk_rise & cpu_clk_fall), 0);
            if (cpu_clk_rise) begin
                chk("rise_level", int'(cpu_clk), 1);
                chk("rise_running", int'(running), 1);
                if (exp_rise.size() == 0) unexpected("rise_unexpected");
                else chk("rise_cycle", cyc, exp_rise.pop_front());
            end
            if (cpu_clk_fall) begin
                chk("fall_level", int'(cpu_clk), 0);
                if (exp_fall.size() == 0) unexpected("fall_unexpected");
                else chk("fall_cycle", cyc, exp_fall.pop_front());
            end
            if (burst_done) begin
                if (exp_done.size() == 0) unexpected("done_unexpected");
                else chk("done_cycle", cyc, exp_done.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    task automatic release_rst(output int k0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        k0 = cyc;
    endtask

    // Each pulse: high for d+1 cycles, low for d+1 cycles, back to back.
    task automatic push_pulses(input int first, input int d, input int n, input int t_end);
        for (int j = 0; j < n; j++) begin
            int r;
            r = first + j * 2 * (d + 1);
            if (r <= t_end) exp_rise.push_back(r);
            if (r + d + 1 <= t_end) exp_fall.push_back(r + d + 1);
        end
    endtask

    // Asynchronous reset at cycle t_end, then check everything is cleared.
    task automatic end_scenario(input string tag, input int t_end, input bit expect_high);
        wait_cyc(t_end);
        #2;
        if (expect_high) chk({tag, "_high_before_reset"}, int'(cpu_clk), 1);
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_cpu_clk"}, int'(cpu_clk), 0);
        chk({tag, "_rst_strobes"}, int'({cpu_clk_rise, cpu_clk_fall, burst_done}), 0);
        chk({tag, "_rst_running"}, int'(running), 0);
        chk({tag, "_rise_left"}, exp_rise.size(), 0);
        chk({tag, "_fall_left"}, exp_fall.size(), 0);
        chk({tag, "_done_left"}, exp_done.size(), 0);
        exp_rise.delete();
        exp_fall.delete();
        exp_done.delete();
        halt = 1'b0;
        manual_toggle = 1'b0;
        step_start = 1'b0;
        step_count = '0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic hold_raw(input logic v, input int n);
        manual_toggle = v;
        wait_cyc(cyc + n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, d, n, t_end, h, s, u, t, len;
        logic b_pat [6];

        @(negedge sys_clk);
        chk("reset_cpu_clk", int'(cpu_clk), 0);
        chk("reset_rise", int'(cpu_clk_rise), 0);
        chk("reset_fall", int'(cpu_clk_fall), 0);
        chk("reset_done", int'(burst_done), 0);
        chk("reset_running", int'(running), 0);

        // Continuous mode with assorted dividers, reset mid-high.
        for (int it = 0; it < 4; it++) begin
            d = (it == 0) ? 2 : $urandom_range(0, 5);
            n = $urandom_range(3, 5);
            mode = 2'b00;
            div = DW'(d);
            release_rst(k0);
            t_end = k0 + 1 + (n - 1) * 2 * (d + 1) + $urandom_range(0, d);
            push_pulses(k0 + 1, d, n, t_end);
            end_scenario("cont", t_end, 1'b1);
        end

        // Continuous with halt one cycle after a rise.
        for (int it = 0; it < 2; it++) begin
            d = (it == 0) ? 3 : $urandom_range(1, 4);
            mode = 2'b00;
            div = DW'(d);
            release_rst(k0);
            push_pulses(k0 + 1, d, 1, k0 + 1000);
            wait_cyc(k0 + 2);
            halt = 1'b1;
            h = k0 + 1 + 2 * (d + 1) + $urandom_range(1, 5);
            wait_cyc(h);
            chk("halt_idle_running", int'(running), 0);
            chk("halt_idle_cpu_clk", int'(cpu_clk), 0);
            t_end = h + 1 + 2 * (d + 1);
            push_pulses(h + 1, d, 2, t_end);
            halt = 1'b0;
            end_scenario("halt", t_end, 1'b1);
        end

        // Manual mode: glitches, a bouncy clean press, a press while halted.
        mode = 2'b01;
        div = DW'(1);
        release_rst(k0);
        for (int g = 0; g < 3; g++) begin
            len = $urandom_range(1, DB - 1);
            hold_raw(1'b1, len);
            hold_raw(1'b0, 8);
        end
        t = cyc;
        push_pulses(t + 3 + DB, 1, 1, t + 1000);
        hold_raw(1'b1, 20);
        b_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) hold_raw(b_pat[i], 1);
        hold_raw(1'b0, 10);
        halt = 1'b1;
        hold_raw(1'b1, 10);
        hold_raw(1'b0, 10);
        halt = 1'b0;
        wait_cyc(cyc + 8);
        d = $urandom_range(0, 3);
        div = DW'(d);
        t = cyc;
        push_pulses(t + 3 + DB, d, 1, t + 1000);
        hold_raw(1'b1, 12);
        hold_raw(1'b0, 14);
        end_scenario("manual", cyc, 1'b0);

        // Burst mode: counted burst, ignored restart, zero count, halt pause.
        for (int it = 0; it < 3; it++) begin
            d = (it == 0) ? 0 : $urandom_range(0, 2);
            n = (it == 0) ? 3 : $urandom_range(1, 5);
            mode = 2'b10;
            div = DW'(d);
            release_rst(k0);
            wait_cyc(k0 + 2);
            s = cyc;
            push_pulses(s + 2, d, n, s + 1000);
            exp_done.push_back(s + 2 + n * 2 * (d + 1));
            step_count = SW'(n);
            step_start = 1'b1;
            wait_cyc(s + 1);
            step_start = 1'b0;
            wait_cyc(s + 3);
            step_count = SW'(7);
            step_start = 1'b1;
            wait_cyc(s + 4);
            step_start = 1'b0;
            u = s + 2 + n * 2 * (d + 1) + 2;
            wait_cyc(u);
            exp_done.push_back(u + 1);
            step_count = '0;
            step_start = 1'b1;
            wait_cyc(u + 1);
            step_start = 1'b0;
            wait_cyc(u + 4);
            s = cyc;
            n = $urandom_range(2, 4);
            step_count = SW'(n);
            step_start = 1'b1;
            push_pulses(s + 2, d, 1, s + 1000);
            wait_cyc(s + 1);
            step_start = 1'b0;
            wait_cyc(s + 2);
            halt = 1'b1;
            h = s + 2 + 2 * (d + 1) + $urandom_range(1, 4);
            wait_cyc(h);
            chk("burst_paused_running", int'(running), 0);
            push_pulses(h + 1, d, n - 1, h + 1000);
            exp_done.push_back(h + 1 + (n - 1) * 2 * (d + 1));
            halt = 1'b0;
            end_scenario("burst", h + 1 + (n - 1) * 2 * (d + 1) + 3, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_clock_gen.md
Name: cpu_clock_gen

Overview:
Parametrised CPU clock generator, successor to the fixed-rate clock block. It supports a runtime-programmable divider, continuous, debounced-manual and N-step burst modes, and halt gating that never truncates a pulse. It sits between the board oscillator/buttons and the CPU core, and supplies cpu_clk plus sys_clk-domain edge strobes for logic that runs synchronously on sys_clk.

Parameters:
DIV_WIDTH, 24, width of the half-period divider input
STEP_WIDTH, 8, width of the burst step count
DEBOUNCE_CYCLES, 250000, number of consecutive stable sys_clk cycles needed to accept a button level change (>=2)

Ports:
sys_clk  in  1  system clock; the only clock in the block
rst_n  in  1  asynchronous, active-low reset
mode  in  2  00 continuous, 01 manual, 10 burst, 11 stopped
div  in  DIV_WIDTH  half-period = div+1 sys_clk cycles
manual_toggle  in  1  raw button, asynchronous to sys_clk, bouncy
step_start  in  1  one-cycle strobe that starts a burst (mode 10 only)
step_count  in  STEP_WIDTH  number of pulses in a burst
halt  in  1  CPU halt request
cpu_clk  out  1  registered CPU clock
cpu_clk_rise  out  1  one-cycle strobe, high in the same cycle cpu_clk first reads 1
cpu_clk_fall  out  1  one-cycle strobe, high in the same cycle cpu_clk first reads 0
burst_done  out  1  one-cycle strobe when a burst completes
running  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; state IDLE; phase counter 0; burst remaining 0; synchroniser and debounced level 0.
- FSM states:
  - IDLE: cpu_clk=0.
  - HIGH: cpu_clk=1.
  - LOW: cpu_clk=0.
- Phase counter: cleared on every state entry. HIGH and LOW each last div+1 cycles. div is sampled on entry to a phase; changing div mid-phase affects only the next phase.
- IDLE -> HIGH on the next edge when any start condition holds:
  - mode=00 and !halt;
  - manual press event and mode=01 and !halt;
  - mode=10 and remaining>0 and !halt.
- HIGH -> LOW when the phase count reaches div. The transition is unconditional; halt never shortens a high phase.
- LOW at the end of its phase:
  - -> HIGH if the continuous or burst condition still holds (manual mode never continues);
  - otherwise -> IDLE.
- Every entry to HIGH decrements remaining when mode=10.
- Continuous-mode period = 2*(div+1). div=0 gives cpu_clk = sys_clk/2.
- halt: checked only at the IDLE or LOW decision points, so an asserted halt lets the current high phase complete and holds cpu_clk low. Deassert while IDLE -> rise on the next edge.
- Mode change takes effect only at the decision points. A mode change from 10 clears remaining with no burst_done.
- Manual path:
  - 2-flop synchroniser, then debouncer.
  - The debounced level updates once the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any reversion resets the count.
  - Each debounced 0->1 edge produces a one-cycle press event.
  - The press is consumed only in IDLE with mode=01 and !halt; otherwise it is discarded, never queued. One press = exactly one full pulse (high div+1, low div+1).
- Burst:
  - step_start in mode=10 with state IDLE and remaining=0 loads remaining=step_count; otherwise it is ignored.
  - step_count=0 -> burst_done on the next cycle, no pulse.
  - burst_done pulses on the LOW->IDLE transition taken because remaining=0.
  - halt during a burst pauses it (remaining is preserved); deassert resumes.
- Strobes: cpu_clk_rise / cpu_clk_fall are registered alongside cpu_clk and are never both high.

Decomposition:
- Package cpu_clock_pkg holds:
  - clk_mode_e (CONT, MANUAL, BURST, STOPPED);
  - clk_state_e (IDLE, HIGH, LOW).
- Sub-module button_debouncer holds the synchroniser and stable counter. Parameter: DEBOUNCE_CYCLES. Ports: sys_clk, rst_n, raw, level, press.

Test Plan:
- Continuous, div=2, halt=0 -> cpu_clk period 6 cycles, 3 high/3 low. cpu_clk_rise every 6 cycles, first rise 1 cycle after reset release.
- Continuous div=3, halt raised 1 cycle after a rise -> high lasts the full 4 cycles, then cpu_clk stays 0 and running=0. halt dropped -> rise on the next cycle.
- Manual, DEBOUNCE_CYCLES=4, div=1:
  - 3-cycle glitches on manual_toggle -> no pulse.
  - Clean press held 20 cycles with bounce on release -> exactly one pulse, 2 high/2 low.
- Burst, div=0, step_count=3, step_start -> exactly 3 rise strobes and burst_done once, in the cycle cpu_clk returns to IDLE. step_start mid-burst is ignored.
- Burst, step_count=0 -> burst_done 1 cycle later, cpu_clk never rises.
- rst_n asserted mid-HIGH -> cpu_clk, strobes and running are 0 immediately (asynchronous). After release in continuous mode, normal periods resume.
